// File: rtl/gf_systolic_multiplier.sv
// gf_systolic_multiplier
//   Digit-serial GF(2)[x] modular multiplier: P = A*B mod (x^M + G), M = W*N.
//   Operands and the reduction tail stream in as W-bit words, most significant
//   word first. One W-bit digit of B is consumed per clock through a chain of
//   W combinational multiply/reduce cells. The product streams out the same way.
//
// Ports
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   ctr  - 0 = start new operation (any state), 1 = run
//   ai   - A word, ai[W] is the highest-degree coefficient
//   bi   - B word, same ordering; leads ai/gi by one cycle
//   gi   - G word (reduction polynomial without the implicit x^M term)
//   po   - product word, po[1] is the highest-degree coefficient; 0 outside
//          the output window
module gf_systolic_multiplier #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctr,
  input  logic [W:1] ai,
  input  logic [W:1] bi,
  input  logic [W:1] gi,
  output logic [1:W] po
);

  localparam int unsigned M  = W * N;
  localparam int unsigned CW = $clog2(3 * N + 2);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LOAD = CW'(N);
  localparam logic [CW-1:0] C_COMP = CW'(2 * N);
  localparam logic [CW-1:0] C_OUT  = CW'(3 * N);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    OUTPUT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] c;
  logic [M-1:0]  a_reg;
  logic [M-1:0]  b_reg;
  logic [M-1:0]  g_reg;
  logic [M-1:0]  p_reg;
  logic [M-1:0]  p_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!ctr) begin
      state_next = LOAD;
    end else begin
      unique case (state)
        LOAD:    if (c == C_LOAD) state_next = COMPUTE;
        COMPUTE: if (c == C_COMP) state_next = OUTPUT;
        OUTPUT:  if (c == C_OUT)  state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  // Cell chain: cell k handles coefficient b_(W-k) of the current top digit
  // (Horner order, highest degree first): P <- P*x mod F  xor  b*A.
  always_comb begin
    p_step = p_reg;
    for (int unsigned k = 0; k < W; k++) begin
      p_step = {p_step[M-2:0], 1'b0}
             ^ (p_step[M-1]     ? g_reg : '0)
             ^ (b_reg[M-1-k]    ? a_reg : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c     <= '0;
      a_reg <= '0;
      b_reg <= '0;
      g_reg <= '0;
      p_reg <= '0;
      po    <= '0;
    end else if (!ctr) begin
      // Start edge: B word N-1 is captured here, so B runs one word ahead.
      c     <= C_ONE;
      a_reg <= '0;
      b_reg <= {(M-W)'(0), bi};
      g_reg <= '0;
      p_reg <= '0;
      po    <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          a_reg <= {a_reg[M-W-1:0], ai};
          g_reg <= {g_reg[M-W-1:0], gi};
          if (c < C_LOAD) b_reg <= {b_reg[M-W-1:0], bi};
          c <= c + C_ONE;
        end
        COMPUTE: begin
          p_reg <= p_step;
          b_reg <= {b_reg[M-W-1:0], W'(0)};
          c     <= c + C_ONE;
        end
        OUTPUT: begin
          po    <= p_reg[M-1 -: W];
          p_reg <= {p_reg[M-W-1:0], W'(0)};
          c     <= c + C_ONE;
        end
        DONE: begin
          po <= '0;
        end
        default: begin
          po <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_systolic_multiplier.sv
module tb_gf_systolic_multiplier;

  localparam int unsigned W = 16;
  localparam int unsigned N = 11;
  localparam int unsigned M = W * N;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctr;
  logic [W:1] ai;
  logic [W:1] bi;
  logic [W:1] gi;
  logic [1:W] po;

  int total = 0;
  int bad   = 0;

  gf_systolic_multiplier #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .ctr (ctr),
    .ai  (ai),
    .bi  (bi),
    .gi  (gi),
    .po  (po)
  );

  always #5 clk = ~clk;

  localparam logic [M-1:0] G0  = 176'h19_2000;
  localparam logic [M-1:0] ONE = 176'h1;
  localparam logic [M-1:0] X   = 176'h1234_5678_9abc_def0_0fed_cba9_8765_4321_a5a5_5a5a_c3c3;
  localparam logic [M-1:0] Y   = 176'hdead_beef_0123_4567_89ab_cdef_f00d_cafe_1357_9bdf_2468;

  function automatic logic [W-1:0] wd(input logic [M-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  // Reference: sum over set bits a_i of B*x^i mod (x^M + G), LSB of A first.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b,
                                          input logic [M-1:0] g);
    logic [M-1:0] r;
    logic [M-1:0] t;
    r = '0;
    t = b;
    for (int i = 0; i < int'(M); i++) begin
      if (a[i]) r = r ^ t;
      t = t[M-1] ? ((t << 1) ^ g) : (t << 1);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start edge plus n_load load edges. Inputs change on negedges.
  task automatic start_op(input logic [M-1:0] a, input logic [M-1:0] b,
                          input logic [M-1:0] g, input int n_load);
    @(negedge clk);
    ctr = 1'b0;
    bi  = wd(b, N - 1);
    ai  = W'($urandom);
    gi  = W'($urandom);
    for (int k = 1; k <= n_load; k++) begin
      @(negedge clk);
      chk("load_po_zero", po, '0);
      ctr = 1'b1;
      ai  = wd(a, N - k);
      gi  = wd(g, N - k);
      bi  = (k < int'(N)) ? wd(b, N - 1 - k) : W'($urandom);
    end
  endtask

  // Observe edges N..2N (po must stay 0), then the N output words.
  task automatic collect(input string tag, input logic [M-1:0] exp);
    for (int k = 0; k <= int'(N); k++) begin
      @(negedge clk);
      chk({tag, "_compute_po_zero"}, po, '0);
      ai = W'($urandom);
      bi = W'($urandom);
      gi = W'($urandom);
    end
    for (int k = 0; k < int'(N); k++) begin
      @(negedge clk);
      chk({tag, "_word"}, po, wd(exp, N - 1 - k));
    end
  endtask

  initial begin
    rst = 1'b0;
    ctr = 1'b1;
    ai  = '0;
    bi  = '0;
    gi  = '0;

    // Reset held with random inputs.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("reset_po", po, '0);
      ctr = 1'($urandom);
      ai  = W'($urandom);
      bi  = W'($urandom);
      gi  = W'($urandom);
    end
    ctr = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_po", po, '0);
    end

    // Identity: 1*1 = 1.
    start_op(ONE, ONE, G0, N);
    collect("identity", ONE);

    // Reduction, back-to-back: x^175 * x = x^176 = G.
    start_op(ONE << 175, 176'h2, G0, N);
    collect("reduce", G0);

    // Small product without reduction: (x+1)(x^2+1) = x^3+x^2+x+1.
    start_op(176'h3, 176'h5, G0, N);
    collect("small", 176'hf);

    // Zero operand.
    start_op('0, Y, G0, N);
    collect("zero_a", '0);

    // Commutativity against the reference model.
    start_op(X, Y, G0, N);
    collect("xy", gf_mul(X, Y, G0));
    start_op(Y, X, G0, N);
    collect("yx", gf_mul(X, Y, G0));

    // Restart at c=5 of LOAD: only the second operands count. Y*1 = Y.
    start_op(X, X, G0, 4);
    start_op(Y, ONE, G0, N);
    collect("restart", Y);

    // Idle in DONE, then start again.
    ctr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_po_zero", po, '0);
    end
    start_op(X, ONE << 175, G0, N);
    collect("after_done", gf_mul(X, ONE << 175, G0));

    // Reset mid-compute aborts: no result may ever appear.
    start_op(X, Y, G0, N);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("abort_po", po, '0);
    @(negedge clk);
    rst = 1'b1;
    ctr = 1'b1;
    for (int k = 0; k < int'(3 * N + 2); k++) begin
      @(negedge clk);
      chk("abort_no_output", po, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
